// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the accumulator ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_READY = 3'd1,
        ST_MUL   = 3'd2,
        ST_ERROR = 3'd3
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // True for the only multi-cycle op.
    function automatic logic is_mul_op(input logic [2:0] code);
        return (code == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier. The first partial product is taken on the
// start edge, so the full 2*WIDTH product is present (done=1) in the cycle
// before the WIDTH-th edge after start; the caller consumes it on that edge.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic                 busy_r;
    logic [2*WIDTH-1:0]   addend_s;
    logic [2*WIDTH-1:0]   first_addend_s;

    // Partial products for the running step and for the start step.
    always_comb begin
        addend_s       = '0;
        first_addend_s = '0;
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = '0;
        end
        if (mplier[0]) begin
            first_addend_s = {{WIDTH{1'b0}}, mcand};
        end else begin
            first_addend_s = '0;
        end
    end

    // Multiplier iteration registers; abort drops the job without a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            prod_r   <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            busy_r   <= 1'b0;
        end else if (abort) begin
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (start && !busy_r) begin
            prod_r   <= first_addend_s;
            mcand_r  <= {{(WIDTH-1){1'b0}}, mcand, 1'b0};
            mplier_r <= {1'b0, mplier[WIDTH-1:1]};
            cnt_r    <= CW'(WIDTH - 1);
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            if (cnt_r != '0) begin
                prod_r   <= prod_r + addend_s;
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                cnt_r    <= cnt_r - CW'(1);
            end else begin
                busy_r <= 1'b0;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy    = busy_r;
    assign done    = busy_r && (cnt_r == '0);
    assign product = prod_r;

endmodule

// File: rtl/alu_accum_seq.sv
// Accumulator ALU with power/error FSM and an optional sequential multiplier.
module alu_accum_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic             clr_err,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             overflow,
    output logic [2:0]       state
);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [WIDTH-1:0]     acc_r;
    logic [WIDTH-1:0]     acc_nxt_s;
    logic                 ovf_r;
    logic                 ovf_nxt_s;
    logic                 ovalid_r;
    logic                 ovalid_nxt_s;
    logic                 mul_start_s;
    logic                 mul_done_s;
    logic                 mul_busy_s;
    logic [2*WIDTH-1:0]   mul_prod_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH-1:0]     alu_res_s;
    logic                 alu_ovf_s;
    logic                 accept_s;

    assign accept_s = in_valid && in_ready;
    assign sum_s    = {1'b0, acc_r} + {1'b0, operand};

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (mul_start_s),
                .abort   (!on),
                .mcand   (acc_r),
                .mplier  (operand),
                .busy    (mul_busy_s),
                .done    (mul_done_s),
                .product (mul_prod_s)
            );
        end else begin : g_no_mul
            assign mul_busy_s = 1'b0;
            assign mul_done_s = 1'b0;
            assign mul_prod_s = '0;
        end
    endgenerate

    // Single-cycle ALU result and its overflow condition.
    always_comb begin
        alu_res_s = acc_r;
        alu_ovf_s = 1'b0;
        case (op)
            OP_AND:  alu_res_s = acc_r & operand;
            OP_OR:   alu_res_s = acc_r | operand;
            OP_XOR:  alu_res_s = acc_r ^ operand;
            OP_NOT:  alu_res_s = ~acc_r;
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_ovf_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                alu_res_s = acc_r - operand;
                alu_ovf_s = (operand > acc_r);
            end
            OP_PASS: alu_res_s = operand;
            default: begin
                alu_res_s = acc_r;
                alu_ovf_s = 1'b0;
            end
        endcase
    end

    // Next state and next datapath values; on=0 overrides everything else.
    always_comb begin
        state_nxt_s  = state_r;
        acc_nxt_s    = acc_r;
        ovf_nxt_s    = ovf_r;
        ovalid_nxt_s = 1'b0;
        mul_start_s  = 1'b0;
        if (!on) begin
            state_nxt_s = ST_OFF;
        end else begin
            case (state_r)
                ST_OFF: state_nxt_s = ST_READY;
                ST_READY: begin
                    if (accept_s) begin
                        if (is_mul_op(op)) begin
                            if (MUL_EN != 0) begin
                                mul_start_s = 1'b1;
                                state_nxt_s = ST_MUL;
                            end else begin
                                ovf_nxt_s   = 1'b1;
                                state_nxt_s = ST_ERROR;
                            end
                        end else begin
                            acc_nxt_s    = alu_res_s;
                            ovalid_nxt_s = 1'b1;
                            if (alu_ovf_s) begin
                                ovf_nxt_s   = 1'b1;
                                state_nxt_s = ST_ERROR;
                            end else begin
                                state_nxt_s = ST_READY;
                            end
                        end
                    end else begin
                        state_nxt_s = ST_READY;
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        acc_nxt_s    = mul_prod_s[WIDTH-1:0];
                        ovalid_nxt_s = 1'b1;
                        if (|mul_prod_s[2*WIDTH-1:WIDTH]) begin
                            ovf_nxt_s   = 1'b1;
                            state_nxt_s = ST_ERROR;
                        end else begin
                            state_nxt_s = ST_READY;
                        end
                    end else if (!mul_busy_s) begin
                        // Multiplier lost its job: resume without a result.
                        state_nxt_s = ST_READY;
                    end else begin
                        state_nxt_s = ST_MUL;
                    end
                end
                ST_ERROR: begin
                    if (clr_err) begin
                        ovf_nxt_s   = 1'b0;
                        state_nxt_s = ST_READY;
                    end else begin
                        state_nxt_s = ST_ERROR;
                    end
                end
                default: state_nxt_s = ST_OFF;
            endcase
        end
    end

    // State, accumulator, sticky flag and result strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_OFF;
            acc_r    <= '0;
            ovf_r    <= 1'b0;
            ovalid_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            acc_r    <= acc_nxt_s;
            ovf_r    <= ovf_nxt_s;
            ovalid_r <= ovalid_nxt_s;
        end
    end

    assign in_ready  = (state_r == ST_READY) && on;
    assign result    = acc_r;
    assign out_valid = ovalid_r;
    assign overflow  = ovf_r;
    assign state     = state_r;

endmodule

// File: tb/tb_alu_accum_seq.sv
// Directed, table-driven bench for alu_accum_seq (WIDTH=8), plus a MUL_EN=0 build.
module tb_alu_accum_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       on, in_valid, clr_err, in_ready, out_valid, overflow;
    logic [2:0] op, state;
    logic [7:0] operand, result;

    logic       on2, in_valid2, clr_err2, in_ready2, out_valid2, overflow2;
    logic [2:0] op2, state2;
    logic [7:0] operand2, result2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] operand;
        logic [7:0] exp_res;
        logic       exp_ovf;
        logic [2:0] exp_state;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    alu_accum_seq #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .on(on), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand(operand), .clr_err(clr_err), .result(result),
        .out_valid(out_valid), .overflow(overflow), .state(state)
    );

    alu_accum_seq #(.WIDTH(8), .MUL_EN(0)) dut_nomul (
        .clk(clk), .rst(rst), .on(on2), .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op2), .operand(operand2), .clr_err(clr_err2), .result(result2),
        .out_valid(out_valid2), .overflow(overflow2), .state(state2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clear an ERROR state and confirm the accumulator is kept.
    task automatic clear_error(input logic [7:0] keep);
        in_valid = 1'b0;
        clr_err  = 1'b1;
        step();
        clr_err  = 1'b0;
        chk("clr_state", 32'(state), 32'd1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_acc", 32'(result), 32'(keep));
        chk("clr_ovalid", 32'(out_valid), 32'd0);
    endtask

    // Load acc with PASS a, run MUL b, check WIDTH-cycle latency and result.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_r, input logic exp_o);
        in_valid = 1'b1; op = 3'b111; operand = a;
        step();
        op = 3'b110; operand = b;
        step();
        in_valid = 1'b0;
        chk("mul_state", 32'(state), 32'd2);
        for (int c = 0; c < 8; c++) begin
            chk("mul_in_ready", 32'(in_ready), 32'd0);
            chk("mul_ovalid_early", 32'(out_valid), 32'd0);
            step();
        end
        chk("mul_result", 32'(result), 32'(exp_r));
        chk("mul_ovalid", 32'(out_valid), 32'd1);
        chk("mul_ovf", 32'(overflow), 32'(exp_o));
        chk("mul_end_state", 32'(state), exp_o ? 32'd3 : 32'd1);
        if (exp_o) begin
            clear_error(exp_r);
        end else begin
            step();
            chk("mul_ovalid_once", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{3'b111, 8'h0F, 8'h0F, 1'b0, 3'd1};
        vecs[1]  = '{3'b000, 8'h3C, 8'h0C, 1'b0, 3'd1};
        vecs[2]  = '{3'b001, 8'h30, 8'h3C, 1'b0, 3'd1};
        vecs[3]  = '{3'b010, 8'hFF, 8'hC3, 1'b0, 3'd1};
        vecs[4]  = '{3'b011, 8'h00, 8'h3C, 1'b0, 3'd1};
        vecs[5]  = '{3'b100, 8'h10, 8'h4C, 1'b0, 3'd1};
        vecs[6]  = '{3'b101, 8'h0C, 8'h40, 1'b0, 3'd1};
        vecs[7]  = '{3'b111, 8'hF0, 8'hF0, 1'b0, 3'd1};
        vecs[8]  = '{3'b100, 8'h20, 8'h10, 1'b1, 3'd3};
        vecs[9]  = '{3'b111, 8'h05, 8'h05, 1'b0, 3'd1};
        vecs[10] = '{3'b101, 8'h06, 8'hFF, 1'b1, 3'd3};
        vecs[11] = '{3'b101, 8'hFF, 8'h00, 1'b0, 3'd1};
        vecs[12] = '{3'b100, 8'hFF, 8'hFF, 1'b0, 3'd1};
        vecs[13] = '{3'b100, 8'h01, 8'h00, 1'b1, 3'd3};
        vecs[14] = '{3'b111, 8'h0C, 8'h0C, 1'b0, 3'd1};

        rst = 1'b1; on = 1'b0; in_valid = 1'b0; op = 3'b000; operand = 8'h00; clr_err = 1'b0;
        on2 = 1'b0; in_valid2 = 1'b0; op2 = 3'b000; operand2 = 8'h00; clr_err2 = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("off_after_rst", 32'(state), 32'd0);
        on = 1'b1;
        step();
        chk("ready_state", 32'(state), 32'd1);

        // Single-cycle ops, back-to-back except where an error must be cleared.
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; op = vecs[i].op; operand = vecs[i].operand;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
            chk($sformatf("v%0d_ovalid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            if (vecs[i].exp_ovf) begin
                chk($sformatf("v%0d_err_in_ready", i), 32'(in_ready), 32'd0);
                clear_error(vecs[i].exp_res);
            end
        end
        in_valid = 1'b0;
        step();
        chk("ovalid_drops", 32'(out_valid), 32'd0);

        run_mul(8'h0C, 8'h0A, 8'h78, 1'b0);
        run_mul(8'h0F, 8'h11, 8'hFF, 1'b0);
        run_mul(8'h10, 8'h10, 8'h00, 1'b1);

        // Power drop three cycles into MUL.
        in_valid = 1'b1; op = 3'b111; operand = 8'h12; step();
        op = 3'b110; operand = 8'h03; step();
        in_valid = 1'b0;
        step(); step();
        on = 1'b0;
        step();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_result", 32'(result), 32'h12);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            cnt += int'(out_valid);
            step();
        end
        on = 1'b1;
        step();
        chk("abort_resume_state", 32'(state), 32'd1);
        for (int c = 0; c < 8; c++) begin
            cnt += int'(out_valid);
            step();
        end
        chk("abort_no_ovalid", 32'(cnt), 32'd0);
        chk("abort_keep_result", 32'(result), 32'h12);

        // Power drop on the completion edge wins over the MUL result.
        in_valid = 1'b1; op = 3'b110; operand = 8'h03; step();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) step();
        on = 1'b0;
        step();
        chk("late_abort_state", 32'(state), 32'd0);
        chk("late_abort_result", 32'(result), 32'h12);
        chk("late_abort_ovalid", 32'(out_valid), 32'd0);
        on = 1'b1;
        step();

        // Power drop wins over clr_err; overflow is retained through OFF.
        in_valid = 1'b1; op = 3'b111; operand = 8'hFF; step();
        op = 3'b100; operand = 8'h01; step();
        in_valid = 1'b0;
        chk("pre_off_state", 32'(state), 32'd3);
        on = 1'b0; clr_err = 1'b1;
        step();
        chk("off_over_clr_state", 32'(state), 32'd0);
        chk("off_keeps_ovf", 32'(overflow), 32'd1);
        on = 1'b1; clr_err = 1'b0;
        step();
        chk("off_to_ready", 32'(state), 32'd1);
        chk("ready_keeps_ovf", 32'(overflow), 32'd1);

        // Asynchronous reset in the middle of MUL.
        in_valid = 1'b1; op = 3'b111; operand = 8'h33; step();
        op = 3'b110; operand = 8'h02; step();
        in_valid = 1'b0;
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_ovalid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_off", 32'(state), 32'd0);
        step();
        chk("arst_ready", 32'(state), 32'd1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            cnt += int'(out_valid);
            step();
        end
        chk("arst_no_partial", 32'(cnt), 32'd0);
        chk("arst_result_zero", 32'(result), 32'd0);

        // MUL_EN=0 build: MUL is illegal.
        on2 = 1'b1;
        step();
        chk("nm_ready", 32'(state2), 32'd1);
        in_valid2 = 1'b1; op2 = 3'b111; operand2 = 8'h5A; step();
        chk("nm_pass", 32'(result2), 32'h5A);
        op2 = 3'b110; operand2 = 8'h02; step();
        in_valid2 = 1'b0;
        chk("nm_mul_state", 32'(state2), 32'd3);
        chk("nm_mul_acc", 32'(result2), 32'h5A);
        chk("nm_mul_ovf", 32'(overflow2), 32'd1);
        chk("nm_mul_ovalid", 32'(out_valid2), 32'd0);
        chk("nm_in_ready", 32'(in_ready2), 32'd0);
        clr_err2 = 1'b1; step(); clr_err2 = 1'b0;
        chk("nm_clr_state", 32'(state2), 32'd1);
        chk("nm_clr_ovf", 32'(overflow2), 32'd0);
        chk("nm_clr_acc", 32'(result2), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "simulation timeout");
    end

endmodule

// File: doc/alu_accum_seq.md
ALU_ACCUM_SEQ -- requirements
Module: alu_accum_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning datapath and accumulator width (legal range 4..32).
REQ-002 The block SHALL have parameter MUL_EN, default 1, meaning the multiply op is implemented; when 0, MUL is treated as an illegal op.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port on, input, 1 bit: power enable.
REQ-006 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: request accepted this cycle if in_valid=1.
REQ-008 The block SHALL have port op, input, 3 bits: operation code.
REQ-009 The block SHALL have port operand, input, WIDTH bits: second operand.
REQ-010 The block SHALL have port clr_err, input, 1 bit: clears the ERROR state.
REQ-011 The block SHALL have port result, output, WIDTH bits: accumulator value.
REQ-012 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse when result is updated.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky overflow or illegal-op flag.
REQ-014 The block SHALL have port state, output, 3 bits: current FSM state.

Function
REQ-015 Op codes SHALL be: 000 AND, 001 OR, 010 XOR, 011 NOT (acc only), 100 ADD, 101 SUB (acc-operand), 110 MUL, 111 PASS (acc=operand).
REQ-016 FSM states SHALL be OFF=0, READY=1, MUL=2, ERROR=3; codes 4..7 SHALL be unused and recover to OFF on the next edge.
REQ-017 OFF: in_ready=0; on=1 SHALL move the FSM to READY at the next edge.
REQ-018 in_ready SHALL equal 1 only in READY with on=1; a request is accepted on an edge where in_valid=in_ready=1.
REQ-019 Non-MUL ops SHALL write the accumulator at the accepting edge, with out_valid=1 for exactly the following cycle (latency 1); back-to-back accepts SHALL be allowed every cycle.
REQ-020 Arithmetic SHALL be unsigned and truncated to WIDTH bits: ADD overflows on carry-out, SUB on borrow (operand > acc), MUL when the upper WIDTH bits of the 2*WIDTH product are nonzero.
REQ-021 MUL SHALL use shift-add: accepted at edge k, FSM is in MUL, in_ready=0, and the result and out_valid appear after edge k+WIDTH.
REQ-022 On overflow, the accumulator SHALL still take the truncated low WIDTH bits, overflow SHALL set, out_valid SHALL pulse, and the FSM SHALL enter ERROR.
REQ-023 An illegal op (MUL with MUL_EN=0) SHALL leave the accumulator unchanged, set overflow, produce no out_valid, and enter ERROR.
REQ-024 ERROR: in_ready=0; clr_err=1 SHALL clear overflow and move the FSM to READY at the next edge; the accumulator SHALL be retained.
REQ-025 on=0 SHALL move any state to OFF at the next edge, aborting MUL with the accumulator unchanged and no out_valid; on=0 takes priority over clr_err and MUL completion.
REQ-026 Accumulator and overflow SHALL be retained through OFF; only rst clears them.

Reset
REQ-027 rst=1 SHALL immediately force state=OFF, result=0, out_valid=0, overflow=0, in_ready=0, and the multiplier counter to 0, regardless of clk.
REQ-028 Deassertion of rst mid-MUL SHALL leave no partial result; the FSM starts in OFF.

Structure
REQ-029 Package alu_pkg SHALL hold the op-code constants, the state encodings and the state typedef.
REQ-030 Sub-module alu_mul_seq (start, busy, done, WIDTH-parameterised shift-add multiplier with a 2*WIDTH product) SHALL implement MUL and SHALL be omitted when MUL_EN=0.

Verification (WIDTH=8)
REQ-031 Test 1: rst, on=1, PASS 0x0F, then AND 0x3C -> result 0x0F then 0x0C, one out_valid each, back-to-back.
REQ-032 Test 2: acc=0xF0, ADD 0x20 -> result 0x10, overflow=1, state ERROR, in_ready=0; clr_err -> READY, overflow=0.
REQ-033 Test 3: acc=0x0C, MUL 0x0A -> in_ready low for 8 cycles, result 0x78 after edge k+8, overflow=0.
REQ-034 Test 4: acc=0x05, SUB 0x06 -> result 0xFF, overflow=1, ERROR.
REQ-035 Test 5: on dropped 3 cycles into MUL (acc=0x12) -> OFF next edge, result stays 0x12, no out_valid; on=1 -> READY.
REQ-036 Test 6: rst asserted asynchronously mid-MUL -> outputs zero before the next clk edge; MUL_EN=0 build: MUL -> ERROR with acc unchanged.
